// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl_pkg
// Description : Shared definitions for the pipeline hazard/stall scheduler:
//               Tuse/Tnew encoding, field widths, MDU latency defaults and
//               the MDU busy-tracker state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

    // Width of the Tuse / Tnew codes carried down the pipeline.
    localparam int T_W = 4;

    // Width of a GPR register number.
    localparam int REG_W = 5;

    // Tuse code for "this operand is not read"; never produces a stall.
    localparam logic [T_W-1:0] TUSE_NONE = 4'd4;

    // MDU latencies, counted from the cycle after issue in E.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Busy down-counter width; must hold the longest latency (DIV_CYCLES).
    localparam int MD_CNT_W = 4;

    // MDU busy-tracker states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

endpackage : hazard_stall_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_stall_ctrl_md_busy_tracker.sv
`default_nettype none
// ============================================================================
// Module      : md_busy_tracker
// Description : Tracks the multi-cycle multiply/divide unit. An issue in E
//               loads a down-counter with the op latency; md_busy is high
//               for exactly that many cycles starting the cycle after issue.
// Ports       : clk         - core clock
//               reset       - synchronous active-low reset (0 = reset)
//               md_start_E  - MDU op issuing in E this cycle
//               md_is_div_E - with md_start_E: 1 = div/divu, 0 = mult/multu
//               md_busy     - MDU result not yet ready (0 during reset)
// Revision    : 1.0 - initial release
// ============================================================================
module md_busy_tracker
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_E,
    input  logic md_is_div_E,
    output logic md_busy
);

    localparam logic [MD_CNT_W-1:0] c_mult_ld = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] c_div_ld  = MD_CNT_W'(DIV_CYCLES);

    md_state_t           r_state;
    logic [MD_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            // Abandons any in-flight operation immediately.
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (md_start_E) begin
                        r_cnt   <= md_is_div_E ? c_div_ld : c_mult_ld;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    // A start while busy cannot legally arrive (the D-stage
                    // MDU stall holds it back) and is ignored here.
                    if (r_cnt == MD_CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - MD_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Forced low during a reset cycle regardless of the current state.
    assign md_busy = reset && (r_state == BUSY);

    a_no_start_while_busy : assert property (
        @(posedge clk) disable iff (!reset)
        !(md_start_E && (r_state == BUSY))
    );

endmodule : md_busy_tracker
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Five-stage pipeline scheduler. Compares D-stage operand
//               demand (Tuse) with E/M producer readiness (Tnew), folds in
//               the MDU busy hazard, and drives the PC enable, IF/ID enable
//               and ID/EX bubble clear. Outputs are combinational.
// Ports       : clk, reset (sync, active-low)
//               rs_addr_D/rt_addr_D, rs_use_D/rt_use_D, md_use_D - D demand
//               dst_addr_E/dst_save_E, dst_addr_M/dst_save_M    - producers
//               md_start_E, md_is_div_E                          - MDU issue
//               pc_en, d_en, e_clr, md_busy                      - controls
//               stall_cnt - saturating stall-cycle counter
// Options     : HAZARD_STALL_CNT_EN - adds CNT_W and the stall_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
`ifdef HAZARD_STALL_CNT_EN
   ,parameter int CNT_W       = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_addr_D,
    input  logic [REG_W-1:0] rt_addr_D,
    input  logic [T_W-1:0]   rs_use_D,
    input  logic [T_W-1:0]   rt_use_D,
    input  logic             md_use_D,
    input  logic [REG_W-1:0] dst_addr_E,
    input  logic [T_W-1:0]   dst_save_E,
    input  logic [REG_W-1:0] dst_addr_M,
    input  logic [T_W-1:0]   dst_save_M,
    input  logic             md_start_E,
    input  logic             md_is_div_E,
    output logic             pc_en,
    output logic             d_en,
    output logic             e_clr,
    output logic             md_busy
`ifdef HAZARD_STALL_CNT_EN
   ,output logic [CNT_W-1:0] stall_cnt
`endif
);

    // Producer X blocks operand s when it targets the same non-zero register,
    // the operand is actually read, and the value arrives after it is needed.
    function automatic logic reg_hazard(
        input logic [REG_W-1:0] dst_addr,
        input logic [T_W-1:0]   dst_save,
        input logic [REG_W-1:0] src_addr,
        input logic [T_W-1:0]   src_use
    );
        return (dst_addr != '0) && (dst_addr == src_addr) &&
               (src_use != TUSE_NONE) && (dst_save > src_use);
    endfunction

    logic w_hz_rs_E;
    logic w_hz_rt_E;
    logic w_hz_rs_M;
    logic w_hz_rt_M;
    logic w_reg_stall;
    logic w_md_stall;
    logic w_stall;

    // W-stage producers have Tnew = 0 and are always covered by forwarding.
    assign w_hz_rs_E = reg_hazard(dst_addr_E, dst_save_E, rs_addr_D, rs_use_D);
    assign w_hz_rt_E = reg_hazard(dst_addr_E, dst_save_E, rt_addr_D, rt_use_D);
    assign w_hz_rs_M = reg_hazard(dst_addr_M, dst_save_M, rs_addr_D, rs_use_D);
    assign w_hz_rt_M = reg_hazard(dst_addr_M, dst_save_M, rt_addr_D, rt_use_D);

    assign w_reg_stall = w_hz_rs_E | w_hz_rt_E | w_hz_rs_M | w_hz_rt_M;

    md_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_tracker (
        .clk         (clk),
        .reset       (reset),
        .md_start_E  (md_start_E),
        .md_is_div_E (md_is_div_E),
        .md_busy     (md_busy)
    );

    // An op issuing in E this cycle already makes the MDU unavailable.
    assign w_md_stall = md_use_D && (md_start_E || md_busy);

    // Gated by reset so a reset cycle always lets the pipeline advance.
    assign w_stall = reset && (w_reg_stall || w_md_stall);

    assign pc_en = ~w_stall;
    assign d_en  = ~w_stall;
    assign e_clr = w_stall;

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule : hazard_stall_ctrl
`default_nettype wire
